alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter LAT_ADD, default 3: cycles from issue to result sample for opcode 2'b00; legal range 1..15.
REQ-002 Parameter LAT_SUB, default 3: same, for opcode 2'b01.
REQ-003 Parameter LAT_MUL, default 10: same, for opcode 2'b10.
REQ-004 Parameter LAT_DIV, default 14: same, for opcode 2'b11.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 req  in  2  per-requester request; bit i = requester i.
REQ-008 opa  in  6  operand A; bits [3i+2:3i] = requester i.
REQ-009 opb  in  6  operand B; bits [3i+2:3i] = requester i.
REQ-010 op  in  4  opcode; bits [2i+1:2i] = requester i (00 add, 01 sub, 10 mul, 11 div).
REQ-011 gnt  out  2  one-cycle grant pulse; operands of that requester captured.
REQ-012 done  out  2  one-cycle completion pulse for requester i.
REQ-013 res  out  12  result; bits [6i+5:6i] = requester i, held until that requester's next done.
REQ-014 alu_portA / alu_portB  out  3 each  operands driven to the shared ALU.
REQ-015 alu_opcode  out  2  opcode driven to the shared ALU.
REQ-016 alu_sal  in  6  ALU result.
REQ-017 busy  out  1  high while an operation is in flight (states RUN and DONE).

Function
REQ-018 FSM states IDLE, RUN, DONE; IDLE -> RUN on grant; RUN -> DONE when latency counter reaches 0; DONE -> IDLE unconditionally after one cycle.
REQ-019 In IDLE with any req bit high, the arbiter SHALL, on that edge, select one requester, pulse its gnt bit, latch its opa/opb/op slices, load counter with the opcode's LAT value minus 1, and enter RUN.
REQ-020 alu_portA/alu_portB/alu_opcode SHALL drive the latched values from the grant edge until the next grant, stable through RUN and DONE.
REQ-021 In RUN, counter decrements once per cycle; at counter==0 the arbiter SHALL sample alu_sal into the granted requester's res slice and enter DONE; result sampled LAT cycles after the grant edge.
REQ-022 In DONE, done[i] of the granted requester SHALL be high for exactly that cycle; no grant is issued in DONE.
REQ-023 Requests are level-sensitive; a req dropped before grant is withdrawn with no gnt or done; req held high after done is a new request.
REQ-024 req changes during RUN/DONE are ignored until IDLE; opa/opb/op changes after grant do not affect the in-flight operation.
REQ-025 res slice of the non-granted requester SHALL never change.
REQ-026 Minimum spacing between consecutive grants is LAT+2 cycles.

Reset
REQ-027 On rst low, asynchronously: state IDLE, counter 0, gnt 0, done 0, res 0, busy 0, alu_portA/alu_portB/alu_opcode 0, round-robin pointer favours requester 0.
REQ-028 Reset during RUN or DONE SHALL abort the operation with no done pulse and no res update; first grant requires rst high at a rising edge.

Configuration
REQ-029 Macro ALU_ARB_ROUNDROBIN_EN defined: on simultaneous req, grant the requester not granted last; pointer updates on every grant.
REQ-030 Macro undefined: fixed priority, requester 0 always wins simultaneous requests; no pointer state; single-request behaviour identical.

Verification
REQ-031 req=01, opa[2:0]=3, opb[2:0]=2, op[1:0]=00, ALU model returns 5 -> gnt=01 at edge 0, done=01 one cycle at edge 4, res[5:0]=5, res[11:6] unchanged.
REQ-032 req=10, op[3:2]=10, opa[5:3]=7, opb[5:3]=7 -> alu_opcode=10 held stable, res[11:6]=49 with done=10 pulse exactly 11 cycles after gnt.
REQ-033 req=11 held continuously, both op=00 -> with macro, grants alternate 01,10,01 every 5 cycles; without macro, every grant is 01.
REQ-034 rst low 3 cycles after a div grant -> busy, gnt, done, res, ALU ports all 0 immediately; no done pulse; next req served normally.
REQ-035 req=01 pulsed for one cycle during RUN of requester 1, dropped before IDLE -> no gnt[0], no done[0], res[5:0] unchanged.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester arbiter in front of one shared multi-cycle ALU.
//               The arbiter grants one requester from IDLE and latches that
//               requester's operands and opcode onto the ALU ports. It then
//               waits the opcode's latency, samples the ALU result into that
//               requester's result slice, and pulses done.
//
//               FSM : IDLE -> RUN (grant) -> DONE (counter hits 0) -> IDLE
//               Grant at edge 0, result sampled at edge LAT, done pulse
//               visible after edge LAT+1. The earliest next grant is at edge
//               LAT+2.
//
// Ports       : clk        - single clock, rising edge
//               rst        - asynchronous, active-low reset
//               req[1:0]   - level-sensitive request, bit i = requester i
//               opa/opb    - 3-bit operand slices, [3i+2:3i] = requester i
//               op[3:0]    - 2-bit opcode slices, [2i+1:2i] = requester i
//               gnt[1:0]   - one-cycle grant pulse
//               done[1:0]  - one-cycle completion pulse
//               res[11:0]  - 6-bit result slices, [6i+5:6i] = requester i
//               alu_portA/alu_portB/alu_opcode - latched values to the ALU
//               alu_sal    - ALU result
//               busy       - operation in flight (RUN and DONE)
//
// Config      : ALU_ARB_ROUNDROBIN_EN - when defined, simultaneous requests
//               alternate between requesters. When undefined, requester 0
//               always wins (fixed priority).
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int LAT_ADD = 3,
    parameter int LAT_SUB = 3,
    parameter int LAT_MUL = 10,
    parameter int LAT_DIV = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [5:0]  opa,
    input  logic [5:0]  opb,
    input  logic [3:0]  op,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [11:0] res,
    output logic [2:0]  alu_portA,
    output logic [2:0]  alu_portB,
    output logic [1:0]  alu_opcode,
    input  logic [5:0]  alu_sal,
    output logic        busy
);

    // The counter is preloaded with LAT-1, so that the result is sampled
    // exactly LAT edges after the grant.
    localparam logic [3:0] c_cnt_add = 4'(LAT_ADD - 1);
    localparam logic [3:0] c_cnt_sub = 4'(LAT_SUB - 1);
    localparam logic [3:0] c_cnt_mul = 4'(LAT_MUL - 1);
    localparam logic [3:0] c_cnt_div = 4'(LAT_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_sel;      // requester owning the in-flight operation
    logic [1:0]  r_gnt;
    logic [1:0]  r_done;
    logic [11:0] r_res;
    logic        r_busy;
    logic [2:0]  r_pa;
    logic [2:0]  r_pb;
    logic [1:0]  r_opc;
`ifdef ALU_ARB_ROUNDROBIN_EN
    logic        r_ptr;      // requester favoured on a tie
`endif

    logic        w_sel;
    logic [2:0]  w_opa;
    logic [2:0]  w_opb;
    logic [1:0]  w_op;
    logic [3:0]  w_cnt_init;

    // Winner selection and operand slicing for the candidate requester.
    always_comb begin
`ifdef ALU_ARB_ROUNDROBIN_EN
        w_sel = (req == 2'b11) ? r_ptr : req[1];
`else
        w_sel = ~req[0];
`endif
        w_opa = w_sel ? opa[5:3] : opa[2:0];
        w_opb = w_sel ? opb[5:3] : opb[2:0];
        w_op  = w_sel ? op[3:2]  : op[1:0];
        case (w_op)
            2'b00:   w_cnt_init = c_cnt_add;
            2'b01:   w_cnt_init = c_cnt_sub;
            2'b10:   w_cnt_init = c_cnt_mul;
            default: w_cnt_init = c_cnt_div;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_sel   <= 1'b0;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_res   <= 12'd0;
            r_busy  <= 1'b0;
            r_pa    <= 3'd0;
            r_pb    <= 3'd0;
            r_opc   <= 2'd0;
`ifdef ALU_ARB_ROUNDROBIN_EN
            r_ptr   <= 1'b0;
`endif
        end else begin
            r_gnt  <= 2'b00;
            r_done <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_gnt   <= w_sel ? 2'b10 : 2'b01;
                        r_sel   <= w_sel;
                        r_pa    <= w_opa;
                        r_pb    <= w_opb;
                        r_opc   <= w_op;
                        r_cnt   <= w_cnt_init;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
`ifdef ALU_ARB_ROUNDROBIN_EN
                        r_ptr   <= ~w_sel;
`endif
                    end
                end
                S_RUN: begin
                    if (r_cnt == 4'd0) begin
                        // Only the owning requester's slice is written.
                        if (r_sel) begin
                            r_res[11:6] <= alu_sal;
                        end else begin
                            r_res[5:0]  <= alu_sal;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // The done pulse is registered here, so it appears one
                    // edge after the result sample.
                    r_done  <= r_sel ? 2'b10 : 2'b01;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign done       = r_done;
    assign res        = r_res;
    assign busy       = r_busy;
    assign alu_portA  = r_pa;
    assign alu_portB  = r_pb;
    assign alu_opcode = r_opc;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed bench for alu_arbiter with a behavioural ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [5:0]  opa;
    logic [5:0]  opb;
    logic [3:0]  op;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [11:0] res;
    logic [2:0]  alu_portA;
    logic [2:0]  alu_portB;
    logic [1:0]  alu_opcode;
    logic [5:0]  alu_sal;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .opa        (opa),
        .opb        (opb),
        .op         (op),
        .gnt        (gnt),
        .done       (done),
        .res        (res),
        .alu_portA  (alu_portA),
        .alu_portB  (alu_portB),
        .alu_opcode (alu_opcode),
        .alu_sal    (alu_sal),
        .busy       (busy)
    );

    function automatic logic [5:0] alu_model(input logic [2:0] a, input logic [2:0] b,
                                             input logic [1:0] o);
        logic [5:0] ea;
        logic [5:0] eb;
        ea = {3'd0, a};
        eb = {3'd0, b};
        case (o)
            2'b00:   return ea + eb;
            2'b01:   return ea - eb;
            2'b10:   return ea * eb;
            default: return (eb == 6'd0) ? 6'h3f : ea / eb;
        endcase
    endfunction

    assign alu_sal = alu_model(alu_portA, alu_portB, alu_opcode);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: busy=%b required 0", busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 2'b00; opa = 6'd0; opb = 6'd0; op = 4'd0;
        @(negedge clk);
        n_vec++; if (gnt !== 2'b00)   begin n_err++; $display("FAIL rst_gnt: got %b required 00", gnt); end
        n_vec++; if (done !== 2'b00)  begin n_err++; $display("FAIL rst_done: got %b required 00", done); end
        n_vec++; if (res !== 12'd0)   begin n_err++; $display("FAIL rst_res: got %h required 000", res); end
        n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_vec++; if ({alu_portA, alu_portB, alu_opcode} !== 8'd0)
            begin n_err++; $display("FAIL rst_alu: got %h required 00", {alu_portA, alu_portB, alu_opcode}); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if ({gnt, busy} !== 3'b000) begin n_err++; $display("FAIL idle_noreq: got %b required 000", {gnt, busy}); end
    endtask

    task automatic test_add();
        req = 2'b01; opa = {3'd0, 3'd3}; opb = {3'd0, 3'd2}; op = 4'b0000;
        @(posedge clk); @(negedge clk);
        n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL add_gnt: got %b required 01", gnt); end
        n_vec++; if ({alu_portA, alu_portB, alu_opcode} !== {3'd3, 3'd2, 2'b00})
            begin n_err++; $display("FAIL add_ports: got %h required %h", {alu_portA, alu_portB, alu_opcode}, {3'd3, 3'd2, 2'b00}); end
        req = 2'b00; opa = 6'h3f; opb = 6'h3f; op = 4'hf;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); @(negedge clk);
            n_vec++; if (done !== ((k == 4) ? 2'b01 : 2'b00))
                begin n_err++; $display("FAIL add_done k=%0d: got %b required %b", k, done, (k == 4) ? 2'b01 : 2'b00); end
            n_vec++; if (gnt !== 2'b00) begin n_err++; $display("FAIL add_nognt k=%0d: got %b required 00", k, gnt); end
            if (k == 2) begin
                n_vec++; if (res !== 12'd0) begin n_err++; $display("FAIL add_res_early: got %h required 000", res); end
            end
            if (k == 3) begin
                n_vec++; if (res !== {6'd0, 6'd5}) begin n_err++; $display("FAIL add_res: got %h required %h", res, {6'd0, 6'd5}); end
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL add_busy_done: got %b required 1", busy); end
            end
            if (k == 4) begin
                n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL add_busy_idle: got %b required 0", busy); end
            end
        end
    endtask

    task automatic test_mul();
        req = 2'b10; opa = {3'd7, 3'd0}; opb = {3'd7, 3'd0}; op = 4'b1000;
        @(posedge clk); @(negedge clk);
        n_vec++; if (gnt !== 2'b10) begin n_err++; $display("FAIL mul_gnt: got %b required 10", gnt); end
        req = 2'b00; opa = 6'd0; opb = 6'd0; op = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); @(negedge clk);
            n_vec++; if ({alu_portA, alu_portB, alu_opcode} !== {3'd7, 3'd7, 2'b10})
                begin n_err++; $display("FAIL mul_ports k=%0d: got %h required %h", k, {alu_portA, alu_portB, alu_opcode}, {3'd7, 3'd7, 2'b10}); end
            n_vec++; if (done !== ((k == 11) ? 2'b10 : 2'b00))
                begin n_err++; $display("FAIL mul_done k=%0d: got %b required %b", k, done, (k == 11) ? 2'b10 : 2'b00); end
            if (k == 9) begin
                n_vec++; if (res !== {6'd0, 6'd5}) begin n_err++; $display("FAIL mul_res_early: got %h required %h", res, {6'd0, 6'd5}); end
            end
            if (k == 10) begin
                n_vec++; if (res !== {6'd49, 6'd5}) begin n_err++; $display("FAIL mul_res: got %h required %h", res, {6'd49, 6'd5}); end
            end
        end
    endtask

    task automatic test_ignore_req();
        req = 2'b10; opa = {3'd1, 3'd0}; opb = {3'd1, 3'd0}; op = 4'b0000;
        @(posedge clk); @(negedge clk);
        n_vec++; if (gnt !== 2'b10) begin n_err++; $display("FAIL ign_gnt: got %b required 10", gnt); end
        req = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); @(negedge clk);
            n_vec++; if (gnt !== 2'b00) begin n_err++; $display("FAIL ign_nognt k=%0d: got %b required 00", k, gnt); end
            n_vec++; if (done !== ((k == 4) ? 2'b10 : 2'b00))
                begin n_err++; $display("FAIL ign_done k=%0d: got %b required %b", k, done, (k == 4) ? 2'b10 : 2'b00); end
            if (k == 1) req = 2'b01;
            if (k == 2) req = 2'b00;
        end
        n_vec++; if (res !== {6'd2, 6'd5}) begin n_err++; $display("FAIL ign_res: got %h required %h", res, {6'd2, 6'd5}); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [3];
`ifdef ALU_ARB_ROUNDROBIN_EN
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01;
`else
        seq[0] = 2'b01; seq[1] = 2'b01; seq[2] = 2'b01;
`endif
        req = 2'b11; opa = {3'd2, 3'd1}; opb = {3'd2, 3'd1}; op = 4'b0000;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); @(negedge clk);
            n_vec++; if (gnt !== ((k % 5 == 0) ? seq[k / 5] : 2'b00))
                begin n_err++; $display("FAIL b2b_gnt k=%0d: got %b required %b", k, gnt, (k % 5 == 0) ? seq[k / 5] : 2'b00); end
        end
        req = 2'b00;
        wait_idle();
    endtask

    task automatic test_reset_abort();
        req = 2'b01; opa = {3'd0, 3'd6}; opb = {3'd0, 3'd2}; op = 4'b0011;
        @(posedge clk); @(negedge clk);
        n_vec++; if ({gnt, alu_opcode} !== {2'b01, 2'b11})
            begin n_err++; $display("FAIL div_gnt: got %b required 0111", {gnt, alu_opcode}); end
        req = 2'b00;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b required 0", busy); end
        n_vec++; if (res !== 12'd0) begin n_err++; $display("FAIL abort_res: got %h required 000", res); end
        n_vec++; if ({gnt, done} !== 4'd0) begin n_err++; $display("FAIL abort_pulses: got %b required 0000", {gnt, done}); end
        n_vec++; if ({alu_portA, alu_portB, alu_opcode} !== 8'd0)
            begin n_err++; $display("FAIL abort_alu: got %h required 00", {alu_portA, alu_portB, alu_opcode}); end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); @(negedge clk);
            n_vec++; if ({done, busy} !== 3'b000)
                begin n_err++; $display("FAIL abort_quiet k=%0d: got %b required 000", k, {done, busy}); end
        end
        req = 2'b01; opa = {3'd0, 3'd1}; opb = {3'd0, 3'd1}; op = 4'b0000;
        @(posedge clk); @(negedge clk);
        n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL post_gnt: got %b required 01", gnt); end
        req = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); @(negedge clk);
            n_vec++; if (done !== ((k == 4) ? 2'b01 : 2'b00))
                begin n_err++; $display("FAIL post_done k=%0d: got %b required %b", k, done, (k == 4) ? 2'b01 : 2'b00); end
        end
        n_vec++; if (res !== {6'd0, 6'd2}) begin n_err++; $display("FAIL post_res: got %h required %h", res, {6'd0, 6'd2}); end
    endtask

    initial begin
        test_reset();
        test_add();
        wait_idle();
        test_mul();
        wait_idle();
        test_ignore_req();
        wait_idle();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
